// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined IEEE-754 style adder/subtractor with valid/ready flow control.
// Build option FP_ADDSUB_SUBNORM_EN enables subnormal operands/results (otherwise flushed to zero).
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] op_a,
  input  logic [EXP_W+MAN_W:0] op_b,
  input  logic                 op_sub,
  input  logic [2:0]           rm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [4:0]           fflags
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int SW   = MAN_W + 4;
  localparam int SH_W = $clog2(SW + 1);
  localparam int EW   = EXP_W + 2;
  localparam int KW   = EXP_W + SW;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EW-1:0] E_ONE = EW'(1);
  localparam logic signed [EW-1:0] E_OVF = $signed({2'b00, EXP_MAX});
  localparam logic [2:0] RM_RTZ = 3'd1, RM_RDN = 3'd2, RM_RUP = 3'd3, RM_RMM = 3'd4;

  // {exponent, hidden, fraction, grs} doubles as a magnitude key
  function automatic logic [KW-1:0] unpack(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
`ifdef FP_ADDSUB_SUBNORM_EN
    if (e == '0) return {{(EXP_W-1){1'b0}}, 1'b1, 1'b0, f, 3'b000};
`else
    if (e == '0) return '0;
`endif
    return {e, 1'b1, f, 3'b000};
  endfunction

  function automatic logic [SW-1:0] align(input logic [SW-1:0] sig, input logic [SH_W-1:0] sh);
    logic [SW-1:0] lost;
    lost = sig & ~({SW{1'b1}} << sh);
    return (sig >> sh) | {{(SW-1){1'b0}}, |lost};
  endfunction

  function automatic logic [SH_W-1:0] lzc(input logic [SW-1:0] v);
    logic [SH_W-1:0] n;
    n = SH_W'(SW);
    for (int i = 0; i < SW; i++)
      if (v[i]) n = SH_W'(SW - 1 - i);
    return n;
  endfunction

  function automatic logic round_up(input logic [2:0] mode, input logic sign, lsb, g, st);
    case (mode)
      RM_RTZ:  return 1'b0;
      RM_RDN:  return sign & (g | st);
      RM_RUP:  return ~sign & (g | st);
      RM_RMM:  return g;
      default: return g & (st | lsb);
    endcase
  endfunction

  logic adv, vld_p1, vld_p2, vld_p3;
  assign out_valid = vld_p3;
  assign in_ready  = !vld_p3 || out_ready;
  assign adv       = in_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else if (adv) begin
      vld_p1 <= in_valid;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  // ---- S1: unpack, classify, swap, align ----
  logic             sa, sb, eff_sub, a_big, nan_a, nan_b, inf_a, inf_b, snan_any;
  logic [EXP_W-1:0] ea, eb, diff;
  logic [MAN_W-1:0] fa, fb;
  logic [KW-1:0]    ua, ub, big, sml;
  logic [SH_W-1:0]  sh;
  logic             s1_spec, s1_nv;
  logic [W-1:0]     s1_spec_res;

  always_comb begin
    sa = op_a[W-1];
    ea = op_a[W-2:MAN_W];
    fa = op_a[MAN_W-1:0];
    sb = op_b[W-1] ^ op_sub;
    eb = op_b[W-2:MAN_W];
    fb = op_b[MAN_W-1:0];
    eff_sub = sa ^ sb;
    ua = unpack(ea, fa);
    ub = unpack(eb, fb);
    a_big = ua >= ub;
    big = a_big ? ua : ub;
    sml = a_big ? ub : ua;
    diff = big[KW-1:SW] - sml[KW-1:SW];
    sh = (diff > EXP_W'(MAN_W + 3)) ? SH_W'(MAN_W + 3) : SH_W'(diff);
    nan_a = (&ea) && (|fa);
    nan_b = (&eb) && (|fb);
    inf_a = (&ea) && !(|fa);
    inf_b = (&eb) && !(|fb);
    snan_any = (nan_a && !fa[MAN_W-1]) || (nan_b && !fb[MAN_W-1]);
    s1_spec = 1'b0;
    s1_nv = 1'b0;
    s1_spec_res = QNAN;
    if (nan_a || nan_b) begin
      s1_spec = 1'b1;
      s1_nv = snan_any;
    end else if (inf_a && inf_b && eff_sub) begin
      s1_spec = 1'b1;
      s1_nv = 1'b1;
    end else if (inf_a || inf_b) begin
      s1_spec = 1'b1;
      s1_spec_res = {inf_a ? sa : sb, EXP_MAX, {MAN_W{1'b0}}};
    end
  end

  logic             spec_p1, nv_p1, sign_p1, sub_p1;
  logic [2:0]       rm_p1;
  logic [W-1:0]     spec_res_p1;
  logic [EXP_W-1:0] exp_p1;
  logic [SW-1:0]    sig_big_p1, sig_sml_p1;

  always_ff @(posedge clk) begin
    if (adv) begin
      spec_p1     <= s1_spec;
      nv_p1       <= s1_nv;
      spec_res_p1 <= s1_spec_res;
      sign_p1     <= a_big ? sa : sb;
      sub_p1      <= eff_sub;
      rm_p1       <= rm;
      exp_p1      <= big[KW-1:SW];
      sig_big_p1  <= big[SW-1:0];
      sig_sml_p1  <= align(sml[SW-1:0], sh);
    end
  end

  // ---- S2: magnitude add / subtract ----
  logic             spec_p2, nv_p2, sign_p2, sub_p2;
  logic [2:0]       rm_p2;
  logic [W-1:0]     spec_res_p2;
  logic [EXP_W-1:0] exp_p2;
  logic [SW:0]      sum_p2;

  always_ff @(posedge clk) begin
    if (adv) begin
      spec_p2     <= spec_p1;
      nv_p2       <= nv_p1;
      spec_res_p2 <= spec_res_p1;
      sign_p2     <= sign_p1;
      sub_p2      <= sub_p1;
      rm_p2       <= rm_p1;
      exp_p2      <= exp_p1;
      sum_p2      <= sub_p1 ? {1'b0, sig_big_p1} - {1'b0, sig_sml_p1}
                            : {1'b0, sig_big_p1} + {1'b0, sig_sml_p1};
    end
  end

  // ---- S3: normalize, round, pack, flags ----
  logic [SW-1:0]          m;
  logic signed [EW-1:0]   e;
  logic [SH_W-1:0]        lz, nsh;
  logic                   g, st, nx, up, tiny, hid, inf_sel;
  logic [MAN_W+1:0]       rnd;
  logic [MAN_W-1:0]       frac;
  logic [W-1:0]           s3_res;
  logic [4:0]             s3_flags;

  always_comb begin
    s3_res = '0;
    s3_flags = '0;
    if (sum_p2[SW]) m = {sum_p2[SW:2], sum_p2[1] | sum_p2[0]};
    else            m = sum_p2[SW-1:0];
    e = $signed({2'b00, exp_p2} + {{(EW-1){1'b0}}, sum_p2[SW]});
    lz = lzc(m);
`ifdef FP_ADDSUB_SUBNORM_EN
    // never normalize below the minimum exponent; what remains is a subnormal
    if (e - $signed({{(EW-SH_W){1'b0}}, lz}) >= E_ONE) nsh = lz;
    else                                               nsh = SH_W'(e - E_ONE);
`else
    nsh = lz;
`endif
    m = m << nsh;
    e = e - $signed({{(EW-SH_W){1'b0}}, nsh});
`ifdef FP_ADDSUB_SUBNORM_EN
    tiny = !m[SW-1];
`else
    tiny = e < E_ONE;
`endif
    g  = m[2];
    st = m[1] | m[0];
    nx = g | st;
    up = round_up(rm_p2, sign_p2, m[3], g, st);
    rnd = {1'b0, m[SW-1:3]} + {{(MAN_W+1){1'b0}}, up};
    if (rnd[MAN_W+1]) begin
      frac = rnd[MAN_W:1];
      hid  = 1'b1;
      e    = e + E_ONE;
    end else begin
      frac = rnd[MAN_W-1:0];
      hid  = rnd[MAN_W];
    end
    case (rm_p2)
      RM_RTZ:  inf_sel = 1'b0;
      RM_RDN:  inf_sel = sign_p2;
      RM_RUP:  inf_sel = !sign_p2;
      default: inf_sel = 1'b1;
    endcase
    if (spec_p2) begin
      s3_res = spec_res_p2;
      s3_flags = {nv_p2, 4'b0000};
    end else if (sum_p2 == '0) begin
      s3_res = {sub_p2 ? (rm_p2 == RM_RDN) : sign_p2, {(W-1){1'b0}}};
`ifndef FP_ADDSUB_SUBNORM_EN
    end else if (tiny) begin
      s3_res = {sign_p2, {(W-1){1'b0}}};
      s3_flags = 5'b00011;
`endif
    end else if (e >= E_OVF) begin
      s3_flags = 5'b00101;
      s3_res = inf_sel ? {sign_p2, EXP_MAX, {MAN_W{1'b0}}}
                       : {sign_p2, EXP_MAX - 1'b1, {MAN_W{1'b1}}};
    end else begin
      s3_res = {sign_p2, hid ? e[EXP_W-1:0] : {EXP_W{1'b0}}, frac};
      s3_flags = {3'b000, tiny & nx, nx};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      fflags <= '0;
    end else if (adv && vld_p2 && !flush) begin
      result <= s3_res;
      fflags <= s3_flags;
    end
  end

endmodule

// File: doc/fp_addsub_pipe.md
FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 23, stored fraction width; operand width W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  synchronous pipeline kill; drops all in-flight operations.
REQ-006 in_valid  input  1  operands/op/rm valid this cycle.
REQ-007 in_ready  output  1  block accepts when in_valid && in_ready.
REQ-008 op_a, op_b  input  W each  IEEE-754 style operands.
REQ-009 op_sub  input  1  0: a+b; 1: a-b (sign of b inverted before alignment).
REQ-010 rm  input  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; others treated as RNE.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-013 result  output  W  rounded sum/difference.
REQ-014 fflags  output  5  {NV,DZ,OF,UF,NX}; DZ is constant 0.

Function
REQ-015 Three-stage pipeline: S1 unpack/classify/swap so |A|>=|B|, align B by exponent difference into a (MAN_W+4)-bit significand with guard, round, sticky (sticky = OR of all bits shifted past); S2 same effective sign -> add, else subtract smaller from larger magnitude, result sign = sign of larger magnitude; S3 leading-zero normalize, round per rm, pack, flags.
REQ-016 Latency exactly 3 cycles from accept to out_valid with out_ready held high; throughput one op per cycle.
REQ-017 Stall: in_ready = !out_valid || out_ready; when low, all stages hold contents and result/fflags stay stable.
REQ-018 Alignment shift saturates at MAN_W+3; larger differences fold all of B into sticky.
REQ-019 Carry-out of add: shift right 1, exponent+1, shifted bit ORed into sticky.
REQ-020 Rounding: RNE ties-to-even; RTZ truncate; RDN/RUP toward -inf/+inf by sign; RMM ties away; rounding carry renormalizes exponent.
REQ-021 NX set when guard|round|sticky nonzero after normalization.
REQ-022 Exact-zero difference of nonzero operands: +0, except -0 when rm=RDN; (+0)+(+0)=+0, (-0)+(-0)=-0.
REQ-023 Overflow (exponent >= all-ones): OF and NX set; result inf for RNE/RMM and for RUP(+)/RDN(-); max finite otherwise.
REQ-024 Infinity: inf +- finite = that inf; same-sign infs = inf; opposite-sign effective infs -> canonical NaN (sign 0, exp all-ones, fraction MSB 1, rest 0), NV set.
REQ-025 Any NaN operand -> canonical NaN; NV set only if a signaling NaN (fraction MSB 0) is present.
REQ-026 Simultaneous accept at input and drain at output in one cycle is legal and loses no data.
REQ-027 flush clears all stage valids next edge; flush has priority over in_valid in that cycle (op not accepted).

Reset
REQ-028 On rst: all stage valids 0, out_valid 0, result all-zeros, fflags 0; in_ready 1 in the first cycle after rst deasserts.
REQ-029 rst asserted mid-operation discards all in-flight ops; none ever appears on the output.

Configuration
REQ-030 Macro FP_ADDSUB_SUBNORM_EN defined: subnormal inputs use exponent 1 with hidden bit 0; tiny results packed as subnormals; UF set when tiny and inexact.
REQ-031 Macro not defined: subnormal inputs treated as same-sign zero; tiny results flushed to same-sign zero with UF and NX set; no subnormal logic synthesized.

Verification
REQ-032 0x3F800000 + 0x40000000, RNE, out_ready=1 -> result 0x40400000, fflags 0, exactly 3 cycles after accept.
REQ-033 0x3F800000 - 0x3F800000 (op_sub=1) -> 0x00000000 with RNE; 0x80000000 with RDN; fflags 0.
REQ-034 0x7F800000 - 0x7F800000 -> 0x7FC00000, NV=1; 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000 OF|NX (RNE), 0x7F7FFFFF OF|NX (RTZ).
REQ-035 0x3F800000 + 0x33800000 (tie) -> 0x3F800000 NX (RNE), 0x3F800001 NX (RUP).
REQ-036 Back-to-back 4 ops, out_ready low 5 cycles after first out_valid -> in_ready low, result stable, all 4 results delivered in order; flush mid-stream -> no output for in-flight ops.
REQ-037 0x00000001 + 0x00000001 -> 0x00000002 fflags 0 with FP_ADDSUB_SUBNORM_EN; 0x00000000 without.
